// File: rtl/common.sv
// Shared types and constants for the multiply/divide unit.
// Holds the request bundle, op and FSM enums, and helpers.
package common;

  localparam int XLEN       = 64;
  localparam int MDU_ITER64 = 64;
  localparam int MDU_ITER32 = 32;

  typedef logic [63:0] u64;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_DIV = 2'd1,
    OP_REM = 2'd2
  } mul_op_t;

  typedef struct packed {
    logic    dw;
    mul_op_t op;
    u64      ia;
    u64      ia_orig;
    u64      ib;
  } mbus_req_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } mdu_state_t;

  // 32-bit results are sign-extended from bit 31
  function automatic u64 fn_fit(input u64 x, input logic dw);
    return dw ? x : {{32{x[31]}}, x[31:0]};
  endfunction

  // magnitude of an N-bit operand, zero-extended to 64 bits
  function automatic u64 fn_mag(input u64 x, input logic dw,
                                input logic neg);
    u64 v;
    v = neg ? -x : x;
    return dw ? v : {32'h0, v[31:0]};
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per cycle; 64 or 32 iterations.
module mdu_divider
  import common::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic i_start,
  input  logic i_abort,
  input  logic i_dw,
  input  u64   i_dividend,
  input  u64   i_divisor,
  output logic o_last,
  output u64   o_quo,
  output u64   o_rem
);

  logic       r_busy;
  logic       r_dw;
  logic [6:0] r_cnt;
  u64         r_quo;
  u64         r_rem;
  u64         r_dvs;

  logic [64:0] w_sh;
  logic [64:0] w_diff;
  logic        w_ge;
  logic [6:0]  w_last_cnt;
  logic        w_unused;

  // remainder stays below the divisor, so the
  // shifted trial never exceeds 65 bits
  assign w_sh       = {r_rem, r_quo[63]};
  assign w_diff     = w_sh - {1'b0, r_dvs};
  assign w_ge       = ~w_diff[64];
  assign w_last_cnt = r_dw ? 7'(MDU_ITER64 - 1)
                           : 7'(MDU_ITER32 - 1);
  assign o_last     = r_busy & (r_cnt == w_last_cnt);
  assign o_quo      = r_quo;
  assign o_rem      = r_rem;
  assign w_unused   = w_sh[64];

  // load operands on start, then shift one quotient bit per cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_busy <= 1'b0;
      r_dw   <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_dw   <= i_dw;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvs  <= i_divisor;
      // 32-bit dividend is left-aligned so bit 63 is always next
      r_quo  <= i_dw ? i_dividend
                     : {i_dividend[31:0], 32'h0};
    end else if (r_busy) begin
      r_rem <= w_ge ? w_diff[63:0] : w_sh[63:0];
      r_quo <= {r_quo[62:0], w_ge};
      r_cnt <= r_cnt + 7'd1;
      if (o_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: FSM, sign handling, multiplier.
// MDU_FAST_MUL_EN selects a single-cycle array multiplier.
module mdu
  import common::*;
#(
  parameter int XLEN = common::XLEN
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      req_valid,
  input  mbus_req_t req,
  input  logic      req_signed,
  output logic      req_ready,
  input  logic      flush,
  output logic      resp_valid,
  output u64        resp_data,
  input  logic      resp_ready
);

  mdu_state_t r_state;
  mul_op_t    r_op;
  logic       r_dw;
  logic       r_neg_q;
  logic       r_neg_r;
  logic       r_resp_valid;
  u64         r_resp_data;

  logic [XLEN-1:0] w_a_lo;
  logic [XLEN-1:0] w_b_lo;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_min;
  logic [XLEN-1:0] w_ones;
  logic [XLEN-1:0] w_spec;
  logic [XLEN-1:0] w_q;
  logic [XLEN-1:0] w_r;
  logic [XLEN-1:0] w_fix;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_is_rem;
  logic            w_accept;
  logic            w_div_start;
  logic            w_div_last;
  u64              w_quo;
  u64              w_rem;
  logic            w_unused;

  assign req_ready  = (r_state == S_IDLE) & ~flush;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign w_accept   = req_valid & req_ready;
  assign w_unused   = ^req.ia_orig;

  assign w_a_lo  = req.dw ? req.ia : {32'h0, req.ia[31:0]};
  assign w_b_lo  = req.dw ? req.ib : {32'h0, req.ib[31:0]};
  assign w_a_neg = req_signed &
                   (req.dw ? req.ia[63] : req.ia[31]);
  assign w_b_neg = req_signed &
                   (req.dw ? req.ib[63] : req.ib[31]);
  assign w_a_mag = fn_mag(req.ia, req.dw, w_a_neg);
  assign w_b_mag = fn_mag(req.ib, req.dw, w_b_neg);

  assign w_min    = req.dw ? {1'b1, 63'h0}
                           : {32'h0, 1'b1, 31'h0};
  assign w_ones   = req.dw ? {64{1'b1}}
                           : {32'h0, 32'hFFFF_FFFF};
  assign w_b_zero = (w_b_lo == '0);
  assign w_ovf    = req_signed & (w_a_lo == w_min) &
                    (w_b_lo == w_ones);
  assign w_is_rem = (req.op == OP_REM);

  // divide-by-zero and signed overflow skip the iteration
  assign w_spec = w_b_zero
    ? (w_is_rem ? fn_fit(req.ia, req.dw) : {64{1'b1}})
    : (w_is_rem ? 64'h0 : fn_fit(req.ia, req.dw));

  assign w_div_start = w_accept & (req.op != OP_MUL) &
                       ~w_b_zero & ~w_ovf;

  // quotient negated on differing signs, remainder follows dividend
  assign w_q   = r_neg_q ? -w_quo : w_quo;
  assign w_r   = r_neg_r ? -w_rem : w_rem;
  assign w_fix = fn_fit((r_op == OP_REM) ? w_r : w_q, r_dw);

`ifdef MDU_FAST_MUL_EN
  logic [XLEN-1:0] w_fast;
  assign w_fast = fn_fit(req.ia * req.ib, req.dw);
`else
  logic [XLEN-1:0] r_ma;
  logic [XLEN-1:0] r_mb;
  logic [XLEN-1:0] r_acc;
  logic [5:0]      r_mcnt;
  logic [XLEN-1:0] w_acc_nxt;
  logic            w_mlast;
  assign w_acc_nxt = r_acc + (r_mb[0] ? r_ma : '0);
  assign w_mlast   = r_mcnt == (r_dw ? 6'(MDU_ITER64 - 1)
                                     : 6'(MDU_ITER32 - 1));
`endif

  mdu_divider u_div (
    .clk        (clk),
    .resetn     (resetn),
    .i_start    (w_div_start),
    .i_abort    (flush),
    .i_dw       (req.dw),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_last     (w_div_last),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  // control FSM with registered response and operand state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_op         <= OP_MUL;
      r_dw         <= 1'b0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
`ifndef MDU_FAST_MUL_EN
      r_ma         <= '0;
      r_mb         <= '0;
      r_acc        <= '0;
      r_mcnt       <= '0;
`endif
    end else if (flush) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= req.op;
            r_dw    <= req.dw;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (req.op == OP_MUL) begin
`ifdef MDU_FAST_MUL_EN
              r_resp_data  <= w_fast;
              r_resp_valid <= 1'b1;
              r_state      <= S_DONE;
`else
              r_ma    <= w_a_lo;
              r_mb    <= w_b_lo;
              r_acc   <= '0;
              r_mcnt  <= '0;
              r_state <= S_MUL;
`endif
            end else if (w_b_zero | w_ovf) begin
              r_resp_data  <= w_spec;
              r_resp_valid <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_state <= S_DIV;
            end
          end
        end
        S_MUL: begin
`ifdef MDU_FAST_MUL_EN
          r_state <= S_IDLE;
`else
          r_acc  <= w_acc_nxt;
          r_ma   <= r_ma << 1;
          r_mb   <= r_mb >> 1;
          r_mcnt <= r_mcnt + 6'd1;
          if (w_mlast) begin
            r_resp_data  <= fn_fit(w_acc_nxt, r_dw);
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end
`endif
        end
        S_DIV: begin
          if (w_div_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_resp_data  <= w_fix;
          r_resp_valid <= 1'b1;
          r_state      <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter: XLEN, default 64, datapath width, taken from package common.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: resetn  input  1  synchronous active-low reset.
REQ-004 Port: req_valid  input  1  EX offers a request this cycle.
REQ-005 Port: req  input  mbus_req_t  fields dw (0: 32-bit, 1: 64-bit), op (MUL/DIV/REM), ia, ia_orig, ib.
REQ-006 Port: req_signed  input  1  signed DIV/REM when 1, unsigned when 0; ignored for MUL.
REQ-007 Port: req_ready  output  1  request accepted when req_valid & req_ready.
REQ-008 Port: flush  input  1  pipeline flush; aborts any in-flight operation.
REQ-009 Port: resp_valid  output  1  resp_data is valid.
REQ-010 Port: resp_data  output  u64  result.
REQ-011 Port: resp_ready  input  1  EX consumes the result when resp_valid & resp_ready.

Function
REQ-012 States SHALL be IDLE, MUL, DIV, FIX, DONE; req_ready=1 only in IDLE with flush=0.
REQ-013 On accept, operands SHALL be latched; dw=0 uses ia[31:0], ib[31:0]; ia_orig is not used by this block.
REQ-014 MUL SHALL return the low N bits of ia*ib (N=64 for dw=1, N=32 for dw=0); dw=0 results SHALL be sign-extended from bit 31.
REQ-015 DIV/REM SHALL use radix-2 restoring division on magnitudes, one quotient bit per cycle, N iterations in DIV, then one cycle in FIX applying signs: quotient negated if operand signs differ, remainder takes the dividend sign.
REQ-016 Divide by zero SHALL give quotient all-ones (N bits) and remainder = dividend, entering DONE directly from IDLE.
REQ-017 Signed overflow (dividend = -2^(N-1), divisor = -1) SHALL give quotient = dividend and remainder 0, entering DONE directly from IDLE.
REQ-018 Latency from accept cycle T: special-case DIV/REM resp_valid at T+1; regular DIV/REM at T+N+2; MUL per REQ-027/028.
REQ-019 In DONE, resp_valid=1 and resp_data SHALL hold stable until resp_ready=1; the handshake cycle returns the FSM to IDLE.
REQ-020 A new request SHALL be acceptable no earlier than the cycle after the response handshake (no overlap).
REQ-021 flush=1 in any state SHALL force IDLE on the next edge and discard the result; flush with req_valid in IDLE SHALL not accept.
REQ-022 resp_valid SHALL be 0 in every state except DONE.

Reset
REQ-023 resetn=0 at a clock edge SHALL force IDLE, resp_valid=0, resp_data=0, all iteration counters and operand registers to 0.
REQ-024 After reset release, req_ready SHALL be 1 in the first cycle.
REQ-025 Reset mid-operation SHALL drop the operation with no response, identical to flush.

Configuration
REQ-026 Macro MDU_FAST_MUL_EN SHALL select the multiplier implementation.
REQ-027 With MDU_FAST_MUL_EN defined: MUL computes with a single-cycle array product, IDLE->DONE, resp_valid at T+1; state MUL is unused.
REQ-028 Without it: MUL uses iterative shift-add, N cycles in MUL, resp_valid at T+N+1.

Structure
REQ-029 mdu_state_t enum, and MDU_ITER64=64, MDU_ITER32=32 constants SHALL live in package common next to mul_op_t and mbus_req_t.
REQ-030 The restoring-division datapath (remainder/quotient shift registers, iteration counter) SHALL be sub-module mdu_divider; FSM, sign handling and multiplier stay in mdu.

Verification
REQ-031 DIV signed dw=1, ia=-7, ib=2 -> resp_data=-3 (0xFFFF_FFFF_FFFF_FFFD) at T+66; REM same operands -> -1.
REQ-032 DIV unsigned dw=0, ia=0x1_0000_0064, ib=10 -> resp_data=10 at T+34 (upper bits of ia ignored).
REQ-033 DIV dw=1, ib=0, ia=5 -> 0xFFFF_FFFF_FFFF_FFFF at T+1; REM -> 5; signed DIV dw=0, ia=0x8000_0000, ib=-1 -> 0xFFFF_FFFF_8000_0000, REM -> 0.
REQ-034 MUL dw=0, ia=0x10000, ib=0x8000 -> 0xFFFF_FFFF_8000_0000; latency T+1 with MDU_FAST_MUL_EN, T+33 without.
REQ-035 Hold resp_ready=0 for 5 cycles in DONE -> resp_data unchanged, req_ready=0; assert resp_ready -> IDLE next cycle.
REQ-036 Assert flush at T+10 of a 64-bit DIV, and separately drive resetn=0 mid-DIV -> IDLE next edge, no resp_valid, next request completes correctly.
